// File: rtl/gnn_pkg.sv
// Shared widths, counts, FSM encoding and flat-vector index helpers for the GNN scheduler.
package gnn_pkg;

    localparam int unsigned DW    = 5;
    localparam int unsigned OW    = 20;
    localparam int unsigned HW    = 12;
    localparam int unsigned NODES = 4;
    localparam int unsigned FEAT  = 4;
    localparam int unsigned HID   = 4;
    localparam int unsigned OUTS  = 2;
    localparam int unsigned NW    = $clog2(NODES);
    localparam int unsigned CW    = 2;
    localparam int unsigned XW    = NODES * FEAT * DW;
    localparam int unsigned W1W   = HID * FEAT * DW;
    localparam int unsigned W2W   = OUTS * HID * DW;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L1   = 3'd1,
        ST_L2   = 3'd2,
        ST_OUT0 = 3'd3,
        ST_OUT1 = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Bit offset of feature k of node n.
    function automatic int unsigned x_base(input int unsigned n, input int unsigned k);
        return (n * FEAT + k) * DW;
    endfunction

    // Bit offset of the weight from input k to hidden j.
    function automatic int unsigned w1_base(input int unsigned j, input int unsigned k);
        return (j * FEAT + k) * DW;
    endfunction

    // Bit offset of the weight from hidden j to output o.
    function automatic int unsigned w2_base(input int unsigned o, input int unsigned j);
        return (o * HID + j) * DW;
    endfunction

endpackage

// File: rtl/gnn_layer_scheduler_mac.sv
// Single signed multiply-accumulate shared by both layers.
module gnn_mac
    import gnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [HW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [OW-1:0] sum_c
);

    localparam int unsigned PW = HW + DW;

    logic signed [PW-1:0] prod_c;
    logic signed [OW-1:0] acc;

    // Product plus either the running sum or zero at the start of a dot product.
    always_comb begin
        prod_c = PW'(a) * PW'(b);
        sum_c  = (clr ? OW'(0) : acc) + OW'(prod_c);
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum_c;
        end
    end

endmodule

// File: rtl/gnn_layer_scheduler.sv
// Time-multiplexes one MAC over a two-layer GNN update for every node, streaming results out.
module gnn_layer_scheduler
    import gnn_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_ready,
    input  logic [XW-1:0]   x_flat,
    input  logic [W1W-1:0]  w1_flat,
    input  logic [W2W-1:0]  w2_flat,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out_data,
    output logic [NW-1:0]   out_node,
    output logic            out_idx,
    output logic            done
);

    state_t              state, state_d;
    logic [XW-1:0]       x_q;
    logic [W1W-1:0]      w1_q;
    logic [W2W-1:0]      w2_q;
    logic [NW-1:0]       node_q, node_d;
    logic [CW-1:0]       hi_q, hi_d;
    logic [CW-1:0]       lo_q, lo_d;
    logic signed [HW-1:0] h_q [HID];
    logic signed [OW-1:0] y0_q, y1_q;

    logic                load, h_we, y_we;
    logic                mac_en, mac_clr;
    logic signed [HW-1:0] mac_a;
    logic signed [DW-1:0] mac_b;
    logic signed [OW-1:0] mac_sum;

    logic                busy_d, valid_d, idx_d, done_d;
    logic [OW-1:0]       data_d;
    logic [NW-1:0]       onode_d;

    gnn_mac u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (mac_a),
        .b     (mac_b),
        .sum_c (mac_sum)
    );

    // Next-state, schedule counters, MAC operand selection and registered-output next values.
    always_comb begin
        state_d = state;
        node_d  = node_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        h_we    = 1'b0;
        y_we    = 1'b0;
        mac_en  = 1'b0;
        mac_clr = 1'b0;
        mac_a   = '0;
        mac_b   = '0;
        case (state)
            ST_IDLE: begin
                if (in_ready) begin
                    load    = 1'b1;
                    node_d  = '0;
                    hi_d    = '0;
                    lo_d    = '0;
                    state_d = ST_L1;
                end
            end
            ST_L1: begin
                mac_en  = 1'b1;
                mac_clr = (lo_q == '0);
                mac_a   = HW'($signed(x_q[x_base(32'(node_q), 32'(lo_q)) +: DW]));
                mac_b   = $signed(w1_q[w1_base(32'(hi_q), 32'(lo_q)) +: DW]);
                lo_d    = lo_q + CW'(1);
                if (lo_q == CW'(FEAT - 1)) begin
                    h_we = 1'b1;
                    if (hi_q == CW'(HID - 1)) begin
                        hi_d    = '0;
                        state_d = ST_L2;
                    end else begin
                        hi_d = hi_q + CW'(1);
                    end
                end
            end
            ST_L2: begin
                mac_en  = 1'b1;
                mac_clr = (lo_q == '0);
                mac_a   = h_q[lo_q];
                mac_b   = $signed(w2_q[w2_base(32'(hi_q), 32'(lo_q)) +: DW]);
                lo_d    = lo_q + CW'(1);
                if (lo_q == CW'(HID - 1)) begin
                    y_we = 1'b1;
                    if (hi_q == CW'(OUTS - 1)) begin
                        hi_d    = '0;
                        state_d = ST_OUT0;
                    end else begin
                        hi_d = hi_q + CW'(1);
                    end
                end
            end
            ST_OUT0: begin
                if (out_ready) begin
                    state_d = ST_OUT1;
                end
            end
            ST_OUT1: begin
                if (out_ready) begin
                    if (node_q == NW'(NODES - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        node_d  = node_q + NW'(1);
                        state_d = ST_L1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d == ST_L1) || (state_d == ST_L2) ||
                  (state_d == ST_OUT0) || (state_d == ST_OUT1);
        valid_d = (state_d == ST_OUT0) || (state_d == ST_OUT1);
        idx_d   = (state_d == ST_OUT1);
        done_d  = (state_d == ST_DONE);
        onode_d = valid_d ? node_d : '0;
        data_d  = (state_d == ST_OUT0) ? y0_q :
                  (state_d == ST_OUT1) ? y1_q : '0;
    end

    // State, counters and latched operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            node_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            x_q    <= '0;
            w1_q   <= '0;
            w2_q   <= '0;
        end else begin
            state  <= state_d;
            node_q <= node_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            if (load) begin
                x_q  <= x_flat;
                w1_q <= w1_flat;
                w2_q <= w2_flat;
            end
        end
    end

    // Hidden activations and output holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HID; i++) begin
                h_q[i] <= '0;
            end
            y0_q <= '0;
            y1_q <= '0;
        end else begin
            if (h_we) begin
                h_q[hi_q] <= mac_sum[HW-1:0];
            end
            if (y_we) begin
                if (hi_q[0]) begin
                    y1_q <= mac_sum;
                end else begin
                    y0_q <= mac_sum;
                end
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_node  <= '0;
            out_idx   <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy      <= busy_d;
            out_valid <= valid_d;
            out_data  <= data_d;
            out_node  <= onode_d;
            out_idx   <= idx_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_gnn_layer_scheduler.sv
// Scoreboard bench for gnn_layer_scheduler: directed jobs, backpressure, mid-job strobe, mid-job reset.
module tb_gnn_layer_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_ready;
    logic [79:0] x_flat;
    logic [79:0] w1_flat;
    logic [39:0] w2_flat;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;
    logic [1:0]  out_node;
    logic        out_idx;
    logic        done;

    gnn_layer_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_ready  (in_ready),
        .x_flat    (x_flat),
        .w1_flat   (w1_flat),
        .w2_flat   (w2_flat),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_node  (out_node),
        .out_idx   (out_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [19:0] data;
        logic [1:0]  node;
        logic        idx;
        int          at;
    } exp_t;

    exp_t res_q[$];
    int   done_q[$];
    int   checks = 0;
    int   errors = 0;
    int   a_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hand-computed results per test vector set.
    function automatic logic [19:0] exp_val(input int tid, input int n, input int o);
        case (tid)
            0: return 20'd16;
            1: return 20'hFFFF0;
            2: return 20'hF0000;
            3: return (o == 0) ? 20'(4 * n + 10) : 20'(14 * n + 28);
            default: return 20'd0;
        endcase
    endfunction

    task automatic set_ops(input int tid);
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 4; k++) begin
                case (tid)
                    2: x_flat[(n*4+k)*5 +: 5] = 5'b10000;
                    3: x_flat[(n*4+k)*5 +: 5] = 5'(n + k + 1);
                    4: x_flat[(n*4+k)*5 +: 5] = 5'd7;
                    default: x_flat[(n*4+k)*5 +: 5] = 5'd1;
                endcase
                case (tid)
                    2: w1_flat[(n*4+k)*5 +: 5] = 5'b10000;
                    3: w1_flat[(n*4+k)*5 +: 5] = (k == (n + 1) % 4) ? 5'd1 : 5'd0;
                    4: w1_flat[(n*4+k)*5 +: 5] = 5'd3;
                    default: w1_flat[(n*4+k)*5 +: 5] = 5'd1;
                endcase
            end
        end
        for (int o = 0; o < 2; o++) begin
            for (int j = 0; j < 4; j++) begin
                case (tid)
                    1: w2_flat[(o*4+j)*5 +: 5] = 5'b11111;
                    2: w2_flat[(o*4+j)*5 +: 5] = 5'b10000;
                    3: w2_flat[(o*4+j)*5 +: 5] = (o == 0) ? 5'd1 : 5'(j * j);
                    4: w2_flat[(o*4+j)*5 +: 5] = 5'b10101;
                    default: w2_flat[(o*4+j)*5 +: 5] = 5'd1;
                endcase
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    // Strobe in_ready for one cycle; a_cyc becomes the acceptance cycle.
    task automatic start_job();
        in_ready = 1'b1;
        a_cyc    = cyc;
        step();
        in_ready = 1'b0;
    endtask

    task automatic push_exp(input int tid, input int base, input int stall, input int nodes, input int with_done);
        exp_t e;
        for (int n = 0; n < nodes; n++) begin
            for (int o = 0; o < 2; o++) begin
                e.data = exp_val(tid, n, o);
                e.node = 2'(n);
                e.idx  = 1'(o);
                e.at   = base + 25 + 26 * n + o + ((stall != 0 && n >= 1) ? 5 : 0);
                res_q.push_back(e);
            end
        end
        if (with_done != 0) done_q.push_back(base + 105 + ((stall != 0) ? 5 : 0));
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((res_q.size() != 0 || done_q.size() != 0) && n < limit) begin
            step();
            n++;
        end
        if (res_q.size() != 0 || done_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results and %0d done pulses still pending", res_q.size(), done_q.size());
            res_q.delete();
            done_q.delete();
        end
    endtask

    task automatic run_job(input int tid, input int stall);
        set_ops(tid);
        start_job();
        push_exp(tid, a_cyc, stall, 4, 1);
        check("busy_cycle1", busy, 1);
        if (stall != 0) begin
            wait_until(a_cyc + 51);
            out_ready = 1'b0;
            wait_until(a_cyc + 56);
            out_ready = 1'b1;
        end
        wait_drain(200);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_node"}, out_node, 0);
        check({tag, "_idx"}, out_idx, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Monitor: pops the scoreboard on every handshake and on every done pulse.
    logic pv = 1'b0, pr = 1'b0, pi = 1'b0;
    logic [19:0] pd = '0;
    logic [1:0]  pn = '0;
    exp_t me;
    int   md;
    always @(negedge clk) begin
        if (rst_n) begin
            if (pv && !pr && out_valid)
                check("stall_hold", {9'd0, out_data, out_node, out_idx}, {9'd0, pd, pn, pi});
            if (out_valid && out_ready) begin
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: data %0h node %0d idx %0d at cycle %0d", out_data, out_node, out_idx, cyc);
                end else begin
                    me = res_q.pop_front();
                    check("result_data", out_data, me.data);
                    check("result_tag", {out_node, out_idx}, {me.node, me.idx});
                    check("result_cycle", cyc, me.at);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: at cycle %0d", cyc);
                end else begin
                    md = done_q.pop_front();
                    check("done_cycle", cyc, md);
                    check("busy_at_done", busy, 0);
                    check("valid_at_done", out_valid, 0);
                end
            end
        end
        pv = out_valid;
        pr = out_ready;
        pd = out_data;
        pn = out_node;
        pi = out_idx;
    end

    initial begin
        rst_n     = 1'b0;
        in_ready  = 1'b0;
        out_ready = 1'b1;
        set_ops(0);
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        run_job(0, 0);
        run_job(1, 0);
        run_job(2, 0);
        run_job(3, 0);
        run_job(0, 1);

        // Strobe with new operands mid-job, then accept a new job right after done.
        set_ops(0);
        start_job();
        push_exp(0, a_cyc, 0, 4, 1);
        wait_until(a_cyc + 10);
        set_ops(4);
        in_ready = 1'b1;
        step();
        in_ready = 1'b0;
        wait_until(a_cyc + 106);
        set_ops(1);
        start_job();
        push_exp(1, a_cyc, 0, 4, 1);
        set_ops(4);
        wait_drain(300);

        // Reset in the middle of node 1.
        set_ops(0);
        start_job();
        push_exp(0, a_cyc, 0, 1, 0);
        wait_until(a_cyc + 40);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        check("pre_reset_pending", res_q.size(), 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (150) step();
        check("post_reset_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gnn_layer_scheduler.md
# gnn_layer_scheduler

Sequencer that time-multiplexes one signed multiply-accumulate unit across the full two-layer GNN node update (4 nodes × 4 features → 4 hidden → 2 outputs). It replaces the fully parallel per-node datapath with a 24-MAC-per-node schedule. Operands are latched on an input strobe, and results are streamed out one 20-bit value at a time over a valid/ready handshake.

## Interface
- `NODES`, 4, number of graph nodes processed per job
- `DW`, 5, signed operand width (features and weights)
- `OW`, 20, result width
- `clk` in 1 — clock, all state on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `in_ready` in 1 — job strobe: operands valid, sampled only in IDLE
- `x_flat` in 80 — features; `x_flat[(n*4+k)*5 +: 5]` = feature k of node n
- `w1_flat` in 80 — layer-1 weights; `[(j*4+k)*5 +: 5]` = input k → hidden j (w{k}{4+j})
- `w2_flat` in 40 — layer-2 weights; `[(o*4+j)*5 +: 5]` = hidden j → output o (w{4+j}{8+o})
- `busy` out 1 — high from the cycle after acceptance until `done`
- `out_valid` out 1 — result valid
- `out_ready` in 1 — consumer accepts result
- `out_data` out 20 — signed result
- `out_node` out 2 — node index of `out_data`
- `out_idx` out 1 — output neuron (0 = out0, 1 = out1)
- `done` out 1 — one-cycle pulse after the last result is accepted

## Operation
- All operands are two's-complement signed 5-bit values.
- Layer 1: h[j] = Σk x[n][k]·w1[j][k]. Products are 10-bit; h is kept at full 12-bit signed width, with no activation and no truncation.
- Layer 2: y[o] = Σj h[j]·w2[o][j]. Products are 17-bit; the sum is 19-bit, sign-extended to 20 bits.
- FSM states: IDLE, L1, L2, OUT0, OUT1, DONE.
- IDLE: when `in_ready` = 1, latch `x_flat`, `w1_flat` and `w2_flat` into internal registers, set node = 0, go to L1. `in_ready` is ignored in every other state.
- L1: 16 cycles, iterating j outer and k inner. The MAC clears at k = 0, and h[j] is written at k = 3.
- L2: 8 cycles, iterating o outer and j inner. y[0] and y[1] go to holding registers.
- OUT0: present y[0] with `out_idx` = 0. On `out_valid & out_ready`, go to OUT1.
- OUT1: present y[1] with `out_idx` = 1. On handshake, if node < NODES-1, increment node and go to L1; otherwise go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE.
- Backpressure: while `out_valid` = 1 and `out_ready` = 0, `out_data`, `out_node` and `out_idx` hold stable and the schedule stalls.
- Later changes to the input ports never affect an accepted job.
- Reset, including mid-job: the FSM goes to IDLE and the counters, MAC and holding registers clear. All outputs (`busy`, `out_valid`, `out_data`, `out_node`, `out_idx`, `done`) read 0. The partial job is discarded and no result is emitted.

## Timing
- Acceptance edge = cycle 0.
- `busy` = 1 from cycle 1.
- L1 occupies cycles 1–16; L2 occupies cycles 17–24.
- Node 0 out0 is valid at cycle 25. With `out_ready` held high, out1 is at cycle 26 and the next node's L1 starts at cycle 27.
- Per-node period is 26 cycles with no stall.
- Last handshake at cycle 104; `done` = 1 and `busy` = 0 at cycle 105.
- IDLE again at cycle 106, where a new `in_ready` is accepted.
- Each stall cycle with `out_ready` = 0 adds exactly one cycle.
- `out_valid` never asserts in the same cycle as `done`.

## Structure
- `gnn_pkg` holds: the DW/OW/HW (12) width constants, the NODES/FEAT/HID/OUTS counts, the FSM state enum, and the flat-vector index helper functions.
- Sub-module `gnn_mac`: a single signed multiply-accumulate with `clr` and `en` inputs, 12×5 signed multiply, and a 20-bit accumulator. Layer-1 operands are sign-extended to feed it.
- The scheduler owns the operand registers, counters (node, j, k/o), the FSM and the output registers.

## Test plan
- All x = 1, all w1 = 1, all w2 = 1; pulse `in_ready`, `out_ready` = 1 → eight results of 16 (node 0–3, idx 0/1) at cycles 25, 26, 51, 52, …; `done` at cycle 105.
- Same job with all w2 = 5'b11111 (−1) → every `out_data` = 20'hFFFF0.
- Extremes: all x, w1 and w2 = 5'b10000 (−16) → h = 1024 and every result = 20'hF0000 (−65536), with no overflow.
- `out_ready` low for 5 cycles at node 1 out0 → `out_data`, `out_node` = 1 and `out_idx` = 0 held stable; `done` shifts to cycle 110.
- `in_ready` re-pulsed mid-job with different operands → ignored; results match the first job; a new `in_ready` in the cycle after `done` (cycle 106) is accepted.
- `rst_n` asserted at cycle 40 → all outputs 0 immediately; no `out_valid` or `done` afterward until a new `in_ready`.
